// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
//  Shared types for the 2-phase req/ack CDC transmitter.
//  cdc_tx_state_e : launch FSM states (IDLE = may launch, WAIT = transfer open).
// ---------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } cdc_tx_state_e;

endpackage

// File: rtl/cdc_2phase_tx_fifo.sv
// ---------------------------------------------------------------------------
// cdc_2phase_tx_fifo
//  DEPTH x DATA_WIDTH synchronous FIFO feeding the CDC launch registers.
//  Ports:
//    clk_i, rst_ni   clock, synchronous active-low reset (empties the FIFO)
//    push_i, data_i  write request and payload (ignored when full)
//    pop_i           drop head entry (ignored when empty)
//    head_o          current head entry
//    full_o, empty_o occupancy flags, from registered pointers only
//    fill_o          number of stored entries
// ---------------------------------------------------------------------------
module cdc_2phase_tx_fifo #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned PW         = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PW-1:0]         fill_o
);
  import cdc_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign fill_o  = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle does not free space for a push while full.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cdc_2phase_tx.sv
// ---------------------------------------------------------------------------
// cdc_2phase_tx
//  Buffered source-domain transmitter for a 2-phase req/ack CDC link.
//  Producer items enter a FIFO; one at a time they are copied into the launch
//  register and announced by toggling async_req_o. The next launch waits until
//  the synchronised ack level matches req again.
//  Ports:
//    clk_i, rst_ni    source clock, synchronous active-low reset
//    data_i, valid_i  producer payload / valid
//    ready_o          FIFO not full
//    async_req_o      2-phase request level (flop output)
//    async_ack_i      2-phase ack level from the receiver (asynchronous)
//    async_data_o     launched payload (flop output, stable while busy_o)
//    fill_o           queued items, not counting the one in flight
//    busy_o           transfer open (req level != synchronised ack level)
//  Timing: async_req_o, async_data_o and async_ack_i need a max_delay of one
//  minimum clock period; req_q, data_q and the sync chain carry dont_touch so
//  they stay single flops driving / receiving the async wires.
// ---------------------------------------------------------------------------
module cdc_2phase_tx #(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned DEPTH       = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned FW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  async_req_o,
  input  logic                  async_ack_i,
  output logic [DATA_WIDTH-1:0] async_data_o,
  output logic [FW-1:0]         fill_o,
  output logic                  busy_o
);
  import cdc_pkg::*;

  cdc_tx_state_e state_q, state_d;

  (* dont_touch = "true" *) logic                   req_q;
  (* dont_touch = "true" *) logic [DATA_WIDTH-1:0]  data_q;
  (* dont_touch = "true" *) logic [SYNC_STAGES-1:0] ack_sync_q;

  logic                  req_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  ack_sync;
  logic                  pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  cdc_2phase_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill_o)
  );

  assign ready_o = !fifo_full;

  // Ack synchroniser: async_ack_i lands directly on stage 0, nothing in front.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ack_sync_q <= '0;
    else         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  // Also covers a spurious ack toggle in IDLE: no launch until the levels re-match.
  assign busy_o   = req_q ^ ack_sync;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !busy_o) begin
          pop     = 1'b1;
          req_d   = ~req_q;
          data_d  = fifo_head;
          state_d = TX_WAIT;
        end
      end
      // Returning to IDLE costs one cycle; the next launch happens from IDLE.
      TX_WAIT: begin
        if (!busy_o) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign async_req_o  = req_q;
  assign async_data_o = data_q;

endmodule

// File: tb/tb_cdc_2phase_tx.sv
`timescale 1ns/1ps
module tb_cdc_2phase_tx;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int FW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0, rclk = 1'b0, rst_ni = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0, async_ack_i = 1'b0;
  logic          ready_o, async_req_o, busy_o;
  logic [DW-1:0] async_data_o;
  logic [FW-1:0] fill_o;

  int checks = 0, errors = 0;

  // Scoreboard: items accepted by the transmitter vs. items seen by the receiver model.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];

  // Receiver model state (destination domain).
  bit   rx_en = 1'b0, rx_rst = 1'b1;
  int   ack_max = 0;
  logic rx_s1 = 1'b0, rx_s2 = 1'b0, rx_ack = 1'b0;
  bit   rx_pend = 1'b0;
  int   rx_cnt = 0;

  bit            mon_en = 1'b0;
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_data = '0;

  cdc_2phase_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .async_req_o  (async_req_o),
    .async_ack_i  (async_ack_i),
    .async_data_o (async_data_o),
    .fill_o       (fill_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #3.3 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 2-phase receiver: synchronise req, capture data on a level change,
  // answer with an ack toggle after a random delay.
  initial begin : rx_model
    forever begin
      @(posedge rclk);
      if (rx_rst) begin
        rx_s1 = 1'b0; rx_s2 = 1'b0; rx_ack = 1'b0; rx_pend = 1'b0; rx_cnt = 0;
        async_ack_i = 1'b0;
      end else begin
        if (rx_en) begin
          if (rx_pend) begin
            if (rx_cnt == 0) begin
              rx_ack = ~rx_ack;
              async_ack_i = rx_ack;
              rx_pend = 1'b0;
            end else begin
              rx_cnt--;
            end
          end else if (rx_s2 != rx_ack) begin
            rx_q.push_back(async_data_o);
            rx_pend = 1'b1;
            rx_cnt = int'($urandom_range(ack_max, 0));
          end
        end
        rx_s2 = rx_s1;
        rx_s1 = async_req_o;
      end
    end
  end

  // Payload must hold for every cycle the transfer stays open.
  always @(negedge clk) begin
    if (mon_en && prev_busy) chk("data_stable", async_data_o, prev_data);
    prev_busy = busy_o;
    prev_data = async_data_o;
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset both ends together; returns at a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; rx_rst = 1'b1; valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1; rx_rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
  endtask

  // Back-to-back pushes of base, base+1, ... one per cycle; rejected items are lost.
  task automatic burst(input logic [DW-1:0] base, input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      data_i = base + DW'(i);
      valid_i = 1'b1;
      if (ready_o) begin
        acc++;
        exp_q.push_back(data_i);
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  task automatic push_wait(input logic [DW-1:0] d);
    int t = 0;
    data_i = d; valid_i = 1'b1;
    while (!ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (ready_o) exp_q.push_back(d);
    else chk("push_timeout", ready_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    int bad = -1;
    int idx;
    while ((rx_q.size() < exp_q.size() || busy_o || fill_o != 0) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    if (exp_q.size() > 0 && rx_q.size() > 0) begin
      idx = (bad >= 0) ? bad : ((rx_q.size() < exp_q.size() ? rx_q.size() : exp_q.size()) - 1);
      chk({tag, "_order"}, rx_q[idx], exp_q[idx]);
    end
    chk({tag, "_fill_end"}, fill_o, 0);
    chk({tag, "_ready_end"}, ready_o, 1);
  endtask

  initial begin : stim
    int acc;
    int ev;
    int t;
    bit prev0;

    // 1. reset held with valid_i asserted
    rst_ni = 1'b0; rx_rst = 1'b1; valid_i = 1'b1; data_i = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fill", fill_o, 0);
    chk("rst_req", async_req_o, 0);
    chk("rst_data", async_data_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    valid_i = 1'b0; rst_ni = 1'b1; rx_rst = 1'b0;

    // 2. single item, ack driven by hand
    @(negedge clk);
    data_i = 32'hDEAD_BEEF; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("t2_fill_e0", fill_o, 1);
    chk("t2_req_e0", async_req_o, 0);
    @(negedge clk);
    chk("t2_req_e1", async_req_o, 1);
    chk("t2_data_e1", async_data_o, 32'hDEAD_BEEF);
    chk("t2_busy_e1", busy_o, 1);
    chk("t2_fill_e1", fill_o, 0);
    async_ack_i = 1'b1;
    repeat (SS - 1) @(negedge clk);
    chk("t2_busy_sync", busy_o, 1);
    repeat (2) @(negedge clk);
    chk("t2_busy_done", busy_o, 0);
    chk("t2_data_hold", async_data_o, 32'hDEAD_BEEF);

    // 3. burst without ack, then deliver
    do_reset();
    rx_en = 1'b0;
    burst(32'h1, 6, acc);
    chk("t3_accepts", 64'(acc), 5);
    chk("t3_ready", ready_o, 0);
    chk("t3_fill", fill_o, 4);
    chk("t3_busy", busy_o, 1);
    ack_max = 0; rx_en = 1'b1;
    push_wait(32'h6);
    drain("t3");

    // 4. random traffic, random ack delays
    ack_max = 20; mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      push_wait($urandom);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    drain("t4");
    mon_en = 1'b0;

    // 5. reset with 3 queued and 1 in flight
    do_reset();
    rx_en = 1'b0;
    burst(32'h10, 4, acc);
    chk("t5_fill_pre", fill_o, 3);
    chk("t5_busy_pre", busy_o, 1);
    do_reset();
    chk("t5_fill", fill_o, 0);
    chk("t5_req", async_req_o, 0);
    chk("t5_data", async_data_o, 0);
    chk("t5_ready", ready_o, 1);
    chk("t5_busy", busy_o, 0);
    ack_max = 0; rx_en = 1'b1;
    push_wait(32'hA5);
    drain("t5");

    // 6. pointer wrap: push exactly when a pop is due, holding fill at 2
    do_reset();
    rx_en = 1'b0;
    burst(32'h100, 3, acc);
    chk("t6_fill_start", fill_o, 2);
    ack_max = 0; rx_en = 1'b1;
    ev = 0; t = 0; prev0 = 1'b0;
    while (ev < 3 * DEPTH + 1 && t < 5000) begin
      // second consecutive idle-looking cycle: the block is in IDLE and pops at the next edge
      if (!busy_o && prev0 && fill_o == 2) begin
        data_i = 32'h200 + DW'(ev); valid_i = 1'b1;
        chk("t6_ready", ready_o, 1);
        exp_q.push_back(data_i);
        @(negedge clk);
        valid_i = 1'b0;
        chk("t6_fill_pp", fill_o, 2);
        chk("t6_launched", busy_o, 1);
        ev++;
        prev0 = 1'b0;
      end else begin
        prev0 = !busy_o;
        @(negedge clk);
      end
      t++;
    end
    chk("t6_events", 64'(ev), 3 * DEPTH + 1);
    drain("t6");
    rx_en = 1'b0;
    burst(32'h300, 6, acc);
    chk("t6_wrap_accepts", 64'(acc), 5);
    chk("t6_wrap_ready", ready_o, 0);
    chk("t6_wrap_fill", fill_o, 4);
    rx_en = 1'b1;
    drain("t6_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
